exec_sequencer: RTL
===================

// Module: exec_sequencer
// PURPOSE
//  Run-state sequencer between the control unit and PC/register file. Consumes fHalt, fHaltIN, out flags.
//  Gates PC advance and state writes; stalls on LOADIN until a debounced button press latches switch input.
//  Holds the OUT display value and counts retired instructions.
// PARAMETERS
//  DATA_W           32         width of switch input, register value and display value
//  DEBOUNCE_CYCLES  1000000    consecutive stable cycles before a button level change is accepted (bench: 4)
//  CNT_W            32         width of retired-instruction counter
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  fHalt        in   1       current instruction is HALT (from control unit)
//  fHaltIN      in   1       current instruction is LOADIN (from control unit)
//  fOut         in   1       current instruction is OUT (control unit 'out')
//  button       in   1       raw asynchronous confirm button, active-high
//  switches     in   DATA_W  raw input data
//  out_value    in   DATA_W  register value selected by the OUT instruction
//  pc_en        out  1       PC may load next address this cycle
//  we_gate      out  1       ANDed with escreveReg and escreveMem at top level
//  in_data      out  DATA_W  latched input, fed to register write mux (memParaReg=11)
//  disp_value   out  DATA_W  value shown on display
//  disp_valid   out  1       disp_value written at least once since reset
//  state        out  2       0 RUNNING, 1 HALTED, 2 WAITING_INPUT, 3 COMMIT
//  instr_count  out  CNT_W   cycles with pc_en=1, saturating
// BEHAVIOUR
//  Reset (sync): state=RUNNING; in_data, disp_value, instr_count=0; disp_valid=0; sync FFs, deb_level, deb_cnt=0.
//  Button path: 2-FF synchronizer -> sync_b. deb_cnt increments while sync_b!=deb_level, clears when equal.
//   When deb_cnt reaches DEBOUNCE_CYCLES-1 with sync_b still different, deb_level<=sync_b, deb_cnt<=0.
//   press = deb_level & ~deb_level_d (1-cycle pulse). Raw stable rise -> press DEBOUNCE_CYCLES+2 cycles later.
//   Press is consumed only in WAITING_INPUT; otherwise discarded, never queued. Glitch < DEBOUNCE_CYCLES: no press.
//  Outputs pc_en/we_gate combinational from state and flags:
//   RUNNING: fHalt -> pc_en=0, we_gate=0, next HALTED. Else fHaltIN -> pc_en=0, we_gate=0, next WAITING_INPUT.
//            Else pc_en=1, we_gate=1; if fOut: disp_value<=out_value, disp_valid<=1 at clock edge.
//            fHalt has priority over fHaltIN; fOut ignored when either is set.
//   HALTED: pc_en=0, we_gate=0; terminal until reset; button ignored.
//   WAITING_INPUT: pc_en=0, we_gate=0; on press: in_data<=switches, next COMMIT.
//   COMMIT: pc_en=1, we_gate=1 (LOADIN still in decode, writes in_data); next RUNNING unconditionally.
//  Latency: fHaltIN seen cycle N -> WAITING_INPUT at N+1; press at M -> COMMIT M+1 -> RUNNING M+2.
//  instr_count += 1 on each edge where pc_en=1; holds at all-ones.
//  disp_value holds between OUT instructions; in_data holds until next accepted press.
//  Button held through reset: deb_level restarts 0, one press after debounce; discarded unless WAITING_INPUT.
//  Reset in any state (incl. WAITING_INPUT/COMMIT) returns to RUNNING next edge; no write occurs.
// TESTING (DEBOUNCE_CYCLES=4)
//  fHaltIN=1 at cycle 10, switches=0x2A, button rises cycle 20 -> press cycle 26, state 2 in 11..26,
//   COMMIT with in_data=0x2A cycle 27 (pc_en=1, we_gate=1), RUNNING cycle 28.
//  In WAITING_INPUT, button high 3 cycles then low -> no press, state stays 2, in_data unchanged.
//  fHalt=1 and fHaltIN=1 same cycle -> HALTED, pc_en=0 permanently; button presses no effect; reset -> RUNNING.
//  fOut=1, out_value=0x1234 -> disp_value=0x1234, disp_valid=1 next cycle; fOut=0 later -> value held.
//  Press in RUNNING, then fHaltIN -> stays WAITING_INPUT (press discarded); reset mid-wait -> RUNNING, in_data=0.
//  CNT_W=3, 10 running cycles -> instr_count saturates at 7; stalled cycles do not increment.

Source files
------------

// File: rtl/exec_sequencer.sv
// Run-state sequencer between the control unit and the PC/register file.
// It gates PC advance and writes, stalls LOADIN until a debounced button press, and holds the OUT display value.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_RUNNING     | normal execution, PC advances, writes enabled
// ST_HALTED      | HALT retired, frozen until reset
// ST_WAIT_INPUT  | LOADIN stalled, waiting for a debounced button press
// ST_COMMIT      | LOADIN writes latched input, PC advances
module exec_sequencer #(
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fHalt,
  input  logic              fHaltIN,
  input  logic              fOut,
  input  logic              button,
  input  logic [DATA_W-1:0] switches,
  input  logic [DATA_W-1:0] out_value,
  output logic              pc_en,
  output logic              we_gate,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [1:0] ST_RUNNING    = 2'd0;
  localparam logic [1:0] ST_HALTED     = 2'd1;
  localparam logic [1:0] ST_WAIT_INPUT = 2'd2;
  localparam logic [1:0] ST_COMMIT     = 2'd3;

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             deb_level;
  logic             deb_level_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  logic [1:0]       state_nxt;
  logic             run_en;
  logic             disp_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a      <= 1'b0;
      sync_b      <= 1'b0;
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync_a      <= button;
      sync_b      <= sync_a;
      deb_level_d <= deb_level;
      if (sync_b != deb_level) begin
        if (deb_cnt == DEB_MAX) begin
          deb_level <= sync_b;
          deb_cnt   <= '0;
        end else begin
          deb_cnt   <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = deb_level & ~deb_level_d;

  always_comb begin
    state_nxt = state;
    run_en    = 1'b0;
    case (state)
      ST_RUNNING: begin
        if (fHalt)        state_nxt = ST_HALTED;
        else if (fHaltIN) state_nxt = ST_WAIT_INPUT;
        else              run_en    = 1'b1;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      ST_WAIT_INPUT: begin
        if (press) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        run_en    = 1'b1;
        state_nxt = ST_RUNNING;
      end
      default: state_nxt = ST_RUNNING;
    endcase
  end

  // Reset suppresses any PC advance or write that the current state would otherwise allow.
  assign pc_en   = run_en & ~reset;
  assign we_gate = run_en & ~reset;
  assign disp_wr = (state == ST_RUNNING) & ~fHalt & ~fHaltIN & fOut;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUNNING;
      in_data     <= '0;
      disp_value  <= '0;
      disp_valid  <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT_INPUT && press) in_data <= switches;
      if (disp_wr) begin
        disp_value <= out_value;
        disp_valid <= 1'b1;
      end
      if (pc_en && (instr_count != {CNT_W{1'b1}})) instr_count <= instr_count + 1'b1;
    end
  end

endmodule
